// File: rtl/main_mem_responder.sv
// Memory-side responder: one outstanding request, fixed latency, single-port word array.
// Optional 4-beat wrapping burst reads are enabled by defining MEM_BURST_EN.
module main_mem_responder #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_rw,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_burst,
  output logic              mem_busy,
  output logic              mem_ack,
  output logic              mem_last,
  output logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // The accepting edge loads LATENCY, so the array access lands LATENCY+1 edges after accept.
  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t            state, state_nx;
  logic [3:0]        cnt;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem_array [2**ADDR_W];
  logic              do_access;
  logic              final_beat;

`ifdef MEM_BURST_EN
  logic              burst_q;
  logic [1:0]        beat;
  assign final_beat = !burst_q || (beat == 2'd3);
`else
  logic              unused_burst;
  assign unused_burst = mem_burst;
  assign final_beat   = 1'b1;
`endif

  assign do_access = (state == ACCESS) && (cnt == 4'd0);

  // NOTE: combinational logic gets a default for every output first, so no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (mem_req) state_nx = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nx = RESP;
      RESP:    if (final_beat) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mem_rdata <= '0;
`ifdef MEM_BURST_EN
      burst_q   <= 1'b0;
      beat      <= 2'd0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (mem_req) begin
            rw_q    <= mem_rw;
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            cnt     <= LAT;
`ifdef MEM_BURST_EN
            burst_q <= mem_burst && !mem_rw;
`endif
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (!rw_q) begin
            mem_rdata <= mem_array[addr_q];
          end
`ifdef MEM_BURST_EN
          beat <= 2'd0;
`endif
        end
        RESP: begin
`ifdef MEM_BURST_EN
          // Each following beat wraps within the 4-word line, critical word first.
          if (!final_beat) begin
            beat      <= beat + 2'd1;
            mem_rdata <= mem_array[{addr_q[ADDR_W-1:2], 2'(addr_q[1:0] + beat + 2'd1)}];
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // NOTE: the word array is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_access && rw_q) mem_array[addr_q] <= wdata_q;
  end

  assign mem_busy = (state != IDLE);
  assign mem_ack  = (state == RESP);
  assign mem_last = mem_ack && final_beat;

endmodule
